// File: rtl/vga_timing_gen.sv
// Parametrised VGA/LCD timing generator: HS/VS/DE, look-ahead pixel request with
// scaled coordinates, run/stop control that only stops on a frame boundary.
module vga_timing_gen #(
    parameter int unsigned CNT_W    = 12,
    parameter int unsigned H_SYNC   = 112,
    parameter int unsigned H_BACK   = 248,
    parameter int unsigned H_DISP   = 1280,
    parameter int unsigned H_FRONT  = 48,
    parameter int unsigned H_TOTAL  = 1688,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BACK   = 38,
    parameter int unsigned V_DISP   = 1024,
    parameter int unsigned V_FRONT  = 1,
    parameter int unsigned V_TOTAL  = 1066,
    parameter int unsigned H_AHEAD  = 1,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             timing_en,
    input  logic [1:0]       scale,
    input  logic [23:0]      lcd_data,
    output logic             lcd_dclk,
    output logic             lcd_hs,
    output logic             lcd_vs,
    output logic             lcd_en,
    output logic [23:0]      lcd_rgb,
    output logic             lcd_request,
    output logic [CNT_W-1:0] lcd_xpos,
    output logic [CNT_W-1:0] lcd_ypos,
    output logic             frame_start,
    output logic             line_start,
    output logic             busy
);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] HA_START = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] HA_END   = CNT_W'(H_SYNC + H_BACK + H_DISP);
    localparam logic [CNT_W-1:0] RQ_START = CNT_W'(H_SYNC + H_BACK - H_AHEAD);
    localparam logic [CNT_W-1:0] RQ_END   = CNT_W'(H_SYNC + H_BACK + H_DISP - H_AHEAD);
    localparam logic [CNT_W-1:0] VA_START = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] VA_END   = CNT_W'(V_SYNC + V_BACK + V_DISP);

    // Elaboration-time sanity on the timing parameters
    if (H_SYNC + H_BACK + H_DISP + H_FRONT != H_TOTAL) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL does not match the sum of the H terms");
    end
    if (V_SYNC + V_BACK + V_DISP + V_FRONT != V_TOTAL) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL does not match the sum of the V terms");
    end
    if (H_AHEAD > H_SYNC + H_BACK) begin : g_bad_h_ahead
        $error("vga_timing_gen: H_AHEAD exceeds H_SYNC+H_BACK");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic [1:0]       scale_q, scale_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
            scale_q <= 2'd0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            scale_q <= scale_d;
        end
    end

    // Next state: a stop request is only honoured at the last pixel of a frame
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        scale_d = scale_q;
        case (state_q)
            IDLE: begin
                h_d = '0;
                v_d = '0;
                if (timing_en) begin
                    state_d = RUN;
                    scale_d = scale;
                end
            end
            RUN: begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    if (v_q == V_LAST) begin
                        v_d = '0;
                        if (timing_en) begin
                            scale_d = scale;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        v_d = v_q + CNT_W'(1);
                    end
                end else begin
                    h_d = h_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic             run;
    logic             act_h, act_v, req_h;
    logic [1:0]       shift;
    logic [CNT_W-1:0] x_raw, y_raw;

    assign run   = (state_q == RUN);
    assign act_h = (h_q >= HA_START) && (h_q < HA_END);
    assign act_v = (v_q >= VA_START) && (v_q < VA_END);
    assign req_h = (h_q >= RQ_START) && (h_q < RQ_END);
    assign shift = (scale_q == 2'd3) ? 2'd0 : scale_q;
    assign x_raw = h_q - RQ_START;
    assign y_raw = v_q - VA_START;

    // Zero-latency output decode of the counter state
    always_comb begin
        lcd_hs      = ~SYNC_POL;
        lcd_vs      = ~SYNC_POL;
        lcd_en      = 1'b0;
        lcd_request = 1'b0;
        lcd_xpos    = '0;
        lcd_ypos    = '0;
        frame_start = 1'b0;
        line_start  = 1'b0;
        if (run) begin
            lcd_hs      = (h_q < HS_END) ? SYNC_POL : ~SYNC_POL;
            lcd_vs      = (v_q < VS_END) ? SYNC_POL : ~SYNC_POL;
            lcd_en      = act_h && act_v;
            lcd_request = req_h && act_v;
            frame_start = (h_q == '0) && (v_q == '0);
            line_start  = (h_q == '0);
            if (req_h && act_v) begin
                lcd_xpos = x_raw >> shift;
                lcd_ypos = y_raw >> shift;
            end
        end
    end

    assign busy     = run;
    assign lcd_rgb  = lcd_en ? lcd_data : 24'd0;
    assign lcd_dclk = ~clk;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen: two instances (active-low sync with lead 2,
// active-high sync with lead 0) checked every cycle against a frame-index model.
module tb_vga_timing_gen;

    localparam int HS = 2, HB = 3, HD = 8, HF = 2, HT = 15;
    localparam int VS = 1, VB = 2, VD = 4, VF = 1, VT = 8;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        timing_en = 1'b0;
    logic [1:0]  scale = 2'd0;
    logic [23:0] lcd_data = 24'd0;

    logic        dclk[2], hs[2], vs[2], en[2], req[2], fs[2], ls[2], bsy[2];
    logic [23:0] rgb[2];
    logic [11:0] xp[2], yp[2];

    int n_chk = 0;
    int n_fail = 0;

    // Reference state: running flag, linear position inside the frame, latched scale
    bit m_run = 1'b0;
    int m_t = 0;
    int m_scale = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CNT_W(12), .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF), .V_TOTAL(VT),
        .H_AHEAD(2), .SYNC_POL(1'b0)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .timing_en(timing_en), .scale(scale), .lcd_data(lcd_data),
        .lcd_dclk(dclk[0]), .lcd_hs(hs[0]), .lcd_vs(vs[0]), .lcd_en(en[0]), .lcd_rgb(rgb[0]),
        .lcd_request(req[0]), .lcd_xpos(xp[0]), .lcd_ypos(yp[0]),
        .frame_start(fs[0]), .line_start(ls[0]), .busy(bsy[0])
    );

    vga_timing_gen #(
        .CNT_W(12), .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF), .V_TOTAL(VT),
        .H_AHEAD(0), .SYNC_POL(1'b1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .timing_en(timing_en), .scale(scale), .lcd_data(lcd_data),
        .lcd_dclk(dclk[1]), .lcd_hs(hs[1]), .lcd_vs(vs[1]), .lcd_en(en[1]), .lcd_rgb(rgb[1]),
        .lcd_request(req[1]), .lcd_xpos(xp[1]), .lcd_ypos(yp[1]),
        .frame_start(fs[1]), .line_start(ls[1]), .busy(bsy[1])
    );

    always @(posedge clk) begin
        if (!rst_n) begin
            m_run = 1'b0; m_t = 0; m_scale = 0;
        end else if (!m_run) begin
            if (timing_en) begin
                m_run = 1'b1; m_t = 0; m_scale = int'(scale);
            end
        end else if (m_t == FRAME - 1) begin
            m_t = 0;
            if (timing_en) m_scale = int'(scale);
            else           m_run = 1'b0;
        end else begin
            m_t = m_t + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int h, v, ahead, s, x, y;
        bit pol, act_h, act_v, e_en, e_req;
        string p;
        h = m_t % HT;
        v = m_t / HT;
        s = (m_scale == 1) ? 1 : (m_scale == 2) ? 2 : 0;
        for (int k = 0; k < 2; k++) begin
            p     = (k == 0) ? "A" : "B";
            ahead = (k == 0) ? 2 : 0;
            pol   = (k == 1);
            act_h = (h >= HS + HB) && (h < HS + HB + HD);
            act_v = (v >= VS + VB) && (v < VS + VB + VD);
            e_en  = m_run && act_h && act_v;
            e_req = m_run && act_v && (h >= HS + HB - ahead) && (h < HS + HB + HD - ahead);
            x     = e_req ? (h - (HS + HB - ahead)) / (1 << s) : 0;
            y     = e_req ? (v - (VS + VB)) / (1 << s) : 0;
            check({p, ".hs"},   32'(hs[k]),  32'(m_run && h < HS ? pol : !pol));
            check({p, ".vs"},   32'(vs[k]),  32'(m_run && v < VS ? pol : !pol));
            check({p, ".en"},   32'(en[k]),  32'(e_en));
            check({p, ".req"},  32'(req[k]), 32'(e_req));
            check({p, ".xpos"}, 32'(xp[k]),  32'(x));
            check({p, ".ypos"}, 32'(yp[k]),  32'(y));
            check({p, ".rgb"},  32'(rgb[k]), e_en ? 32'(lcd_data) : 32'd0);
            check({p, ".fs"},   32'(fs[k]),  32'(m_run && m_t == 0));
            check({p, ".ls"},   32'(ls[k]),  32'(m_run && h == 0));
            check({p, ".busy"}, 32'(bsy[k]), 32'(m_run));
            check({p, ".dclk"}, 32'(dclk[k]), 32'd1);
        end
    endtask

    // One cycle: check at the falling edge, then present fresh pixel data
    task automatic step();
        @(negedge clk);
        check_all();
        lcd_data = 24'($urandom);
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_pos(input int x, input int y, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (m_run && m_t == y * HT + x) break;
            step();
        end
        if (i == budget) check("wait_pos_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int gap;
        // Reset and first frame at 1x; measure the frame period
        rst_n = 1'b0; timing_en = 1'b0; scale = 2'd0;
        run_steps(3);
        rst_n = 1'b1;
        run_steps(2);
        timing_en = 1'b1;
        step();
        gap = 0;
        for (int i = 0; i < 500; i++) begin
            step();
            gap++;
            if (fs[0]) break;
        end
        check("frame_period", 32'(gap), 32'(FRAME));
        run_steps(FRAME);

        // 2x from a frame start, then request 4x mid-frame
        scale = 2'd1;
        wait_pos(0, 0, 2 * FRAME);
        wait_pos(0, 4, 2 * FRAME);
        scale = 2'd2;
        run_steps(2 * FRAME);

        // Stop after the current frame, then restart
        wait_pos(3, 4, 2 * FRAME);
        timing_en = 1'b0;
        run_steps(FRAME);
        check("stopped_busy", 32'(bsy[0]), 32'd0);
        timing_en = 1'b1;
        scale = 2'd3;
        run_steps(5);

        // Drop and re-raise before the end of frame: no gap
        wait_pos(0, 4, 2 * FRAME);
        timing_en = 1'b0;
        wait_pos(0, 6, 2 * FRAME);
        timing_en = 1'b1;
        run_steps(FRAME);

        // Synchronous reset mid-frame, then a glitch that misses the clock edge
        scale = 2'd2;
        wait_pos(6, 4, 2 * FRAME);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run_steps(20);
        wait_pos(6, 2, 2 * FRAME);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        run_steps(20);

        // Random run/stop/scale/reset traffic
        for (int i = 0; i < 3000; i++) begin
            timing_en = ($urandom % 6) != 0;
            if ($urandom % 16 == 0) scale = 2'($urandom);
            rst_n = ($urandom % 400) != 0;
            step();
        end
        rst_n = 1'b1;
        run_steps(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
